// File: rtl/cpsr_flag_arbiter.sv
// Arbitrates MUL retire, MSR and ALU flag writes onto the single CPSR write port.
// Latency: grants are combinational; the winning write appears on the CPSR inputs one cycle later.
// Backpressure: MUL retire always wins; MSR/ALU hold until granted; mul_issue is refused at MAX_PENDING.
module cpsr_flag_arbiter #(
  parameter int MAX_PENDING = 2,
  parameter int CNT_W       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mul_issue,
  output logic       mul_issue_ready,
  input  logic       mul_req,
  input  logic [3:0] mul_flags,
  input  logic       mul_keep_c,
  input  logic       msr_req,
  input  logic [3:0] msr_flags,
  input  logic       alu_req,
  input  logic [3:0] alu_flags,
  input  logic       alu_keep_c,
  output logic       msr_gnt,
  output logic       alu_gnt,
  output logic       flags_busy,
  output logic       update_CPSR,
  output logic       ignore_C_flag,
  output logic       N_flag_temp,
  output logic       Z_flag_temp,
  output logic       C_flag_temp,
  output logic       V_flag_temp,
  output logic       protocol_err
);

  localparam logic [CNT_W-1:0] MaxPend = CNT_W'(MAX_PENDING);

  // Scoreboard of outstanding flag-setting multiplies.
  logic [CNT_W-1:0] pending_q, pending_d;
  // Write stage toward the CPSR block.
  logic             upd_q, upd_d;
  logic [3:0]       flags_q, flags_d;
  logic             keep_c_q, keep_c_d;
  // Sticky retire-without-issue indication.
  logic             protocol_err_q, protocol_err_d;

  logic             pend_zero;
  logic             issue_acc;

  assign pend_zero = (pending_q == '0);

  // A retire in the same cycle frees a slot, so issue stays open at the limit.
  assign mul_issue_ready = (pending_q < MaxPend) | mul_req;
  assign issue_acc       = mul_issue & mul_issue_ready;

  // MSR and ALU are held off while any multiply is outstanding, so none can overtake it.
  assign msr_gnt = msr_req & ~mul_req & pend_zero;
  assign alu_gnt = alu_req & ~mul_req & ~msr_req & pend_zero;

  // Select the winning write for the next cycle; flag values hold when nothing wins.
  always_comb begin
    upd_d    = 1'b0;
    flags_d  = flags_q;
    keep_c_d = 1'b0;
    if (mul_req) begin
      upd_d    = 1'b1;
      flags_d  = mul_flags;
      keep_c_d = mul_keep_c;
    end else if (msr_gnt) begin
      upd_d    = 1'b1;
      flags_d  = msr_flags;
      keep_c_d = 1'b0;
    end else if (alu_gnt) begin
      upd_d    = 1'b1;
      flags_d  = alu_flags;
      keep_c_d = alu_keep_c;
    end
  end

  // Pending counter: issue increments, retire decrements, both together cancel; never wraps below zero.
  always_comb begin
    pending_d = pending_q;
    if (issue_acc && !mul_req) begin
      pending_d = pending_q + 1'b1;
    end else if (mul_req && !issue_acc && !pend_zero) begin
      pending_d = pending_q - 1'b1;
    end
  end

  // A retire with nothing outstanding flags a producer bug until reset; the write still goes through.
  always_comb begin
    protocol_err_d = protocol_err_q;
    if (mul_req && pend_zero) begin
      protocol_err_d = 1'b1;
    end
  end

  // State registers; reset discards the scoreboard and any write in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q      <= '0;
      upd_q          <= 1'b0;
      flags_q        <= 4'b0000;
      keep_c_q       <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      upd_q          <= upd_d;
      flags_q        <= flags_d;
      keep_c_q       <= keep_c_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign update_CPSR   = upd_q;
  assign ignore_C_flag = keep_c_q;
  assign N_flag_temp   = flags_q[3];
  assign Z_flag_temp   = flags_q[2];
  assign C_flag_temp   = flags_q[1];
  assign V_flag_temp   = flags_q[0];
  assign protocol_err  = protocol_err_q;

  // CPSR is coherent only once nothing is outstanding, in flight, or being granted.
  assign flags_busy = ~pend_zero | upd_q | mul_req | msr_gnt | alu_gnt;

endmodule

// File: tb/tb_cpsr_flag_arbiter.sv
// Directed bench for cpsr_flag_arbiter with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are compared 1-2ns later.
// No open-ended waits: every step is a fixed number of cycles.
module tb_cpsr_flag_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       mul_issue, mul_req, mul_keep_c;
  logic [3:0] mul_flags;
  logic       msr_req;
  logic [3:0] msr_flags;
  logic       alu_req, alu_keep_c;
  logic [3:0] alu_flags;
  logic       mul_issue_ready, msr_gnt, alu_gnt, flags_busy;
  logic       update_CPSR, ignore_C_flag;
  logic       N_flag_temp, Z_flag_temp, C_flag_temp, V_flag_temp;
  logic       protocol_err;
  logic [3:0] flg;

  int checks = 0;
  int errors = 0;

  cpsr_flag_arbiter #(.MAX_PENDING(2), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .mul_issue(mul_issue), .mul_issue_ready(mul_issue_ready),
    .mul_req(mul_req), .mul_flags(mul_flags), .mul_keep_c(mul_keep_c),
    .msr_req(msr_req), .msr_flags(msr_flags),
    .alu_req(alu_req), .alu_flags(alu_flags), .alu_keep_c(alu_keep_c),
    .msr_gnt(msr_gnt), .alu_gnt(alu_gnt), .flags_busy(flags_busy),
    .update_CPSR(update_CPSR), .ignore_C_flag(ignore_C_flag),
    .N_flag_temp(N_flag_temp), .Z_flag_temp(Z_flag_temp),
    .C_flag_temp(C_flag_temp), .V_flag_temp(V_flag_temp),
    .protocol_err(protocol_err)
  );

  assign flg = {N_flag_temp, Z_flag_temp, C_flag_temp, V_flag_temp};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b0;
    mul_issue = 0; mul_req = 0; mul_keep_c = 0; mul_flags = 4'h0;
    msr_req = 0; msr_flags = 4'h0;
    alu_req = 0; alu_keep_c = 0; alu_flags = 4'h0;

    // Reset state
    #3;
    chk("rst_upd", {7'd0, update_CPSR}, 8'd0);
    chk("rst_ign", {7'd0, ignore_C_flag}, 8'd0);
    chk("rst_flg", {4'd0, flg}, 8'd0);
    chk("rst_perr", {7'd0, protocol_err}, 8'd0);
    chk("rst_gnt", {6'd0, msr_gnt, alu_gnt}, 8'd0);
    #4 reset = 1'b1;
    tick(); tick();
    chk("idle_upd", {7'd0, update_CPSR}, 8'd0);
    chk("idle_busy", {7'd0, flags_busy}, 8'd0);
    chk("idle_rdy", {7'd0, mul_issue_ready}, 8'd1);

    // ALU write with C preserved
    alu_req = 1; alu_flags = 4'b0110; alu_keep_c = 1;
    settle();
    chk("alu_gnt_k", {6'd0, msr_gnt, alu_gnt}, 8'd1);
    chk("alu_busy_k", {7'd0, flags_busy}, 8'd1);
    tick();
    alu_req = 0;
    settle();
    chk("alu_upd_k1", {7'd0, update_CPSR}, 8'd1);
    chk("alu_flg_k1", {4'd0, flg}, 8'h06);
    chk("alu_ign_k1", {7'd0, ignore_C_flag}, 8'd1);
    chk("alu_busy_k1", {7'd0, flags_busy}, 8'd1);
    tick();
    chk("alu_upd_k2", {7'd0, update_CPSR}, 8'd0);
    chk("alu_busy_k2", {7'd0, flags_busy}, 8'd0);
    chk("alu_hold_k2", {4'd0, flg}, 8'h06);

    // Priority: MUL > MSR > ALU with one multiply pending
    mul_issue = 1;
    settle();
    chk("pri_rdy0", {7'd0, mul_issue_ready}, 8'd1);
    tick();
    mul_issue = 0;
    mul_req = 1; mul_flags = 4'b1001; mul_keep_c = 0;
    msr_req = 1; msr_flags = 4'b0011;
    alu_req = 1; alu_flags = 4'b1111; alu_keep_c = 0;
    settle();
    chk("pri_gnt_k", {6'd0, msr_gnt, alu_gnt}, 8'd0);
    chk("pri_busy_k", {7'd0, flags_busy}, 8'd1);
    tick();
    mul_req = 0;
    settle();
    chk("pri_upd_k1", {7'd0, update_CPSR}, 8'd1);
    chk("pri_flg_k1", {4'd0, flg}, 8'h09);
    chk("pri_gnt_k1", {6'd0, msr_gnt, alu_gnt}, 8'd2);
    tick();
    msr_req = 0;
    settle();
    chk("pri_flg_k2", {4'd0, flg}, 8'h03);
    chk("pri_ign_k2", {7'd0, ignore_C_flag}, 8'd0);
    chk("pri_gnt_k2", {6'd0, msr_gnt, alu_gnt}, 8'd1);
    tick();
    alu_req = 0;
    settle();
    chk("pri_flg_k3", {4'd0, flg}, 8'h0F);
    chk("pri_upd_k3", {7'd0, update_CPSR}, 8'd1);
    tick();
    chk("pri_busy_end", {7'd0, flags_busy}, 8'd0);

    // Scoreboard saturation at MAX_PENDING=2
    mul_issue = 1;
    tick();
    settle();
    chk("sat_rdy1", {7'd0, mul_issue_ready}, 8'd1);
    tick();
    alu_req = 1; alu_flags = 4'b0101; alu_keep_c = 0;
    settle();
    chk("sat_rdy2", {7'd0, mul_issue_ready}, 8'd0);
    chk("sat_alu_blk0", {7'd0, alu_gnt}, 8'd0);
    tick();
    mul_issue = 0;
    settle();
    chk("sat_third_ign", {7'd0, mul_issue_ready}, 8'd0);
    mul_req = 1; mul_flags = 4'b1000; mul_keep_c = 1;
    settle();
    chk("sat_retire_rdy", {7'd0, mul_issue_ready}, 8'd1);
    chk("sat_alu_blk1", {7'd0, alu_gnt}, 8'd0);
    tick();
    mul_req = 0;
    settle();
    chk("sat_r1_flg", {4'd0, flg}, 8'h08);
    chk("sat_r1_ign", {7'd0, ignore_C_flag}, 8'd1);
    chk("sat_alu_blk2", {7'd0, alu_gnt}, 8'd0);
    chk("sat_rdy_p1", {7'd0, mul_issue_ready}, 8'd1);
    tick();
    chk("sat_idle_upd", {7'd0, update_CPSR}, 8'd0);
    chk("sat_alu_blk3", {7'd0, alu_gnt}, 8'd0);
    mul_req = 1; mul_flags = 4'b0100; mul_keep_c = 0;
    settle();
    chk("sat_alu_blk4", {7'd0, alu_gnt}, 8'd0);
    tick();
    mul_req = 0;
    settle();
    chk("sat_alu_go", {7'd0, alu_gnt}, 8'd1);
    chk("sat_r2_flg", {4'd0, flg}, 8'h04);
    tick();
    alu_req = 0;
    settle();
    chk("sat_alu_flg", {4'd0, flg}, 8'h05);
    chk("sat_alu_ign", {7'd0, ignore_C_flag}, 8'd0);
    tick();
    chk("sat_busy_end", {7'd0, flags_busy}, 8'd0);

    // Simultaneous issue and retire at pending=2
    mul_issue = 1;
    tick();
    tick();
    mul_req = 1; mul_flags = 4'b0010; mul_keep_c = 0;
    settle();
    chk("sim_rdy", {7'd0, mul_issue_ready}, 8'd1);
    tick();
    mul_issue = 0; mul_req = 0;
    settle();
    chk("sim_upd", {7'd0, update_CPSR}, 8'd1);
    chk("sim_flg", {4'd0, flg}, 8'h02);
    chk("sim_still2", {7'd0, mul_issue_ready}, 8'd0);
    mul_req = 1; mul_flags = 4'b0001;
    tick();
    tick();
    mul_req = 0;
    settle();
    chk("sim_drain_rdy", {7'd0, mul_issue_ready}, 8'd1);
    chk("sim_drain_flg", {4'd0, flg}, 8'h01);
    tick();
    chk("sim_busy_end", {7'd0, flags_busy}, 8'd0);
    chk("sim_no_perr", {7'd0, protocol_err}, 8'd0);

    // Retire with nothing pending
    mul_req = 1; mul_flags = 4'b1110; mul_keep_c = 1;
    settle();
    chk("perr_pre", {7'd0, protocol_err}, 8'd0);
    tick();
    mul_req = 0;
    settle();
    chk("perr_set", {7'd0, protocol_err}, 8'd1);
    chk("perr_upd", {7'd0, update_CPSR}, 8'd1);
    chk("perr_flg", {4'd0, flg}, 8'h0E);
    chk("perr_ign", {7'd0, ignore_C_flag}, 8'd1);
    tick();
    chk("perr_nowrap_busy", {7'd0, flags_busy}, 8'd0);
    chk("perr_nowrap_rdy", {7'd0, mul_issue_ready}, 8'd1);
    tick(); tick();
    chk("perr_sticky", {7'd0, protocol_err}, 8'd1);

    // Reset in the middle of a write with a multiply outstanding
    alu_req = 1; alu_flags = 4'b1011; alu_keep_c = 1; mul_issue = 1;
    settle();
    chk("mid_alu_gnt", {7'd0, alu_gnt}, 8'd1);
    tick();
    alu_req = 0; mul_issue = 0;
    settle();
    chk("mid_upd_pre", {7'd0, update_CPSR}, 8'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_upd_drop", {7'd0, update_CPSR}, 8'd0);
    chk("mid_flg_clr", {4'd0, flg}, 8'd0);
    chk("mid_perr_clr", {7'd0, protocol_err}, 8'd0);
    chk("mid_busy", {7'd0, flags_busy}, 8'd0);
    tick();
    #1 reset = 1'b1;
    tick();
    chk("post_busy", {7'd0, flags_busy}, 8'd0);
    chk("post_upd", {7'd0, update_CPSR}, 8'd0);
    chk("post_rdy", {7'd0, mul_issue_ready}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
